// File: rtl/dpram_pkg.sv
// Shared sizing for the track-loader sector buffers.
package dpram_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 14;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/dpram_sync.sv
// Single-clock true dual-port RAM with registered reads on both ports.
// Port A faces the SD block-transfer side, port B the disk-controller side.
module dpram_sync
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents start at zero and survive reset; only the output registers clear.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic [DATA_WIDTH-1:0] q_a_d, q_a_q;
  logic [DATA_WIDTH-1:0] q_b_d, q_b_q;

  // Reads see pre-edge contents, so the other port's write is not visible yet.
  always_comb begin
    q_a_d = '0;
    q_b_d = '0;
    if (!reset) begin
      q_a_d = wren_a ? data_a : mem[address_a];
      q_b_d = wren_b ? data_b : mem[address_b];
    end
  end

  // Port B write is ordered last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    q_a_q <= q_a_d;
    q_b_q <= q_b_d;
    if (!reset) begin
      if (wren_a) mem[address_a] <= data_a;
      if (wren_b) mem[address_b] <= data_b;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: tb/tb_dpram_sync.sv
// Randomised and directed checks of dpram_sync against an array reference model.
module tb_dpram_sync;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a, q_b;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_a, exp_b;
  int n_tests = 0;
  int n_fail  = 0;

  dpram_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .address_a (address_a),
    .wren_a    (wren_a),
    .data_a    (data_a),
    .q_a       (q_a),
    .address_b (address_b),
    .wren_b    (wren_b),
    .data_b    (data_b),
    .q_b       (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
  endtask

  // Advance one edge; the model predicts each port's output from the RAM rules.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp_a = '0;
      exp_b = '0;
    end else begin
      exp_a = wren_a ? data_a : ref_mem[address_a];
      exp_b = wren_b ? data_b : ref_mem[address_b];
      if (wren_a) ref_mem[address_a] = data_a;
      if (wren_b) ref_mem[address_b] = data_b;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 14'h0005, 8'hAA, 1'b1, 14'h0005, 8'hBB);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (q_a !== 8'h00) begin n_fail++; $display("FAIL reset_q_a: got %h want 00", q_a); end
      n_tests++;
      if (q_b !== 8'h00) begin n_fail++; $display("FAIL reset_q_b: got %h want 00", q_b); end
    end
    reset = 1'b0;
    drive(1'b0, 14'h0005, 8'h00, 1'b0, 14'h0005, 8'h00);
    tick();
    n_tests++;
    if (q_a !== exp_a) begin n_fail++; $display("FAIL reset_suppress_a: got %h want %h", q_a, exp_a); end
    n_tests++;
    if (q_b !== exp_b) begin n_fail++; $display("FAIL reset_suppress_b: got %h want %h", q_b, exp_b); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] vals [3];
    addrs = '{14'h01FF, 14'h0000, 14'h3FFF};
    vals  = '{8'h5C, 8'h11, 8'hEE};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addrs[i], vals[i], 1'b0, 14'h1234, 8'h00);
      tick();
      n_tests++;
      if (q_a !== exp_a) begin n_fail++; $display("FAIL basic_wr_thru_a[%0d]: got %h want %h", i, q_a, exp_a); end
      drive(1'b0, 14'h0001, 8'h00, 1'b0, addrs[i], 8'h00);
      tick();
      n_tests++;
      if (q_b !== exp_b) begin n_fail++; $display("FAIL basic_rd_b[%0d]: got %h want %h", i, q_b, exp_b); end
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, AW'(i), DW'(i), 1'b0, 14'h2000, 8'h00);
      tick();
      n_tests++;
      if (q_a !== exp_a) begin n_fail++; $display("FAIL burst_wr_a@%0h: got %h want %h", i, q_a, exp_a); end
    end
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, AW'(i), 8'h00, 1'b0, AW'(i), 8'h00);
      tick();
      n_tests++;
      if (q_a !== exp_a || q_b !== exp_b) begin
        n_fail++;
        $display("FAIL burst_rd@%0h: got a=%h b=%h want a=%h b=%h", i, q_a, q_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_old_data();
    drive(1'b1, 14'h0010, 8'h33, 1'b0, 14'h0000, 8'h00);
    tick();
    drive(1'b1, 14'h0010, 8'h44, 1'b0, 14'h0010, 8'h00);
    tick();
    n_tests++;
    if (q_a !== exp_a) begin n_fail++; $display("FAIL old_data_wr_thru_a: got %h want %h", q_a, exp_a); end
    n_tests++;
    if (q_b !== exp_b) begin n_fail++; $display("FAIL old_data_b: got %h want %h", q_b, exp_b); end
    drive(1'b0, 14'h0000, 8'h00, 1'b0, 14'h0010, 8'h00);
    tick();
    n_tests++;
    if (q_b !== exp_b) begin n_fail++; $display("FAIL old_data_next_b: got %h want %h", q_b, exp_b); end
  endtask

  task automatic test_collision();
    drive(1'b1, 14'h0020, 8'h12, 1'b1, 14'h0020, 8'h34);
    tick();
    n_tests++;
    if (q_a !== exp_a) begin n_fail++; $display("FAIL collide_a: got %h want %h", q_a, exp_a); end
    n_tests++;
    if (q_b !== exp_b) begin n_fail++; $display("FAIL collide_b: got %h want %h", q_b, exp_b); end
    drive(1'b0, 14'h0020, 8'h00, 1'b0, 14'h0020, 8'h00);
    tick();
    n_tests++;
    if (q_a !== exp_a || q_b !== exp_b) begin
      n_fail++;
      $display("FAIL collide_rd: got a=%h b=%h want a=%h b=%h", q_a, q_b, exp_a, exp_b);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 256; i++) begin
      reset = (i == 8'h80);
      drive(1'b1, AW'(14'h0200 + i), DW'(i), 1'b0, 14'h3000, 8'h00);
      tick();
      n_tests++;
      if (q_a !== exp_a || q_b !== exp_b) begin
        n_fail++;
        $display("FAIL rst_burst@%0h: got a=%h b=%h want a=%h b=%h", i, q_a, q_b, exp_a, exp_b);
      end
    end
    reset = 1'b0;
    for (int i = 8'h7F; i <= 8'h81; i++) begin
      drive(1'b0, 14'h0000, 8'h00, 1'b0, AW'(14'h0200 + i), 8'h00);
      tick();
      n_tests++;
      if (q_b !== exp_b) begin n_fail++; $display("FAIL rst_burst_rd@%0h: got %h want %h", i, q_b, exp_b); end
    end
  endtask

  // Narrow address window plus the extremes to provoke frequent collisions.
  task automatic test_random();
    logic [AW-1:0] ra, rb;
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 14'h3FFF : AW'($urandom_range(0, 7));
      rb = ($urandom_range(0, 9) == 0) ? 14'h3FFF : AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), ra, DW'($urandom), 1'($urandom), rb, DW'($urandom));
      tick();
      n_tests++;
      if (q_a !== exp_a || q_b !== exp_b) begin
        n_fail++;
        $display("FAIL random[%0d]: got a=%h b=%h want a=%h b=%h", i, q_a, q_b, exp_a, exp_b);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    test_reset();
    test_basic();
    test_burst();
    test_old_data();
    test_collision();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
